// File: rtl/dmem_arbiter_if.sv
// Signal bundle for the data-memory arbiter: core request path, host/loader
// request path and the shared DMEM port. The master side is the surrounding system.
interface dmem_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [1:0]  core_wsel;
  logic [2:0]  core_rsel;
  logic [31:0] core_rdata;
  logic        core_stall;

  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [1:0]  host_wsel;
  logic [2:0]  host_rsel;
  logic        host_gnt;
  logic [31:0] host_rdata;
  logic        host_rvalid;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [1:0]  mem_wsel;
  logic [2:0]  mem_rsel;
  logic [31:0] mem_rdata;

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_wsel, core_rsel,
           host_req, host_we, host_addr, host_wdata, host_wsel, host_rsel,
           mem_rdata,
    input  core_rdata, core_stall, host_gnt, host_rdata, host_rvalid,
           mem_addr, mem_wdata, mem_rw, mem_wsel, mem_rsel
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_wsel, core_rsel,
           host_req, host_we, host_addr, host_wdata, host_wsel, host_rsel,
           mem_rdata,
    output core_rdata, core_stall, host_gnt, host_rdata, host_rvalid,
           mem_addr, mem_wdata, mem_rw, mem_wsel, mem_rsel
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the DMEM port between the core (default owner) and a host/loader port.
// Define DMEM_ARB_FAIR_EN to force a host slot after HOST_WAIT_MAX lost cycles.
module dmem_arbiter #(
  parameter int unsigned HOST_WAIT_MAX = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  if (HOST_WAIT_MAX < 1 || HOST_WAIT_MAX > 255) begin : g_bad_wait_max
    $error("dmem_arbiter: HOST_WAIT_MAX must be in 1..255");
  end

  typedef enum logic {
    S_CORE = 1'b0,
    S_HOST = 1'b1
  } state_t;

  state_t      state;
  logic        host_win;
  logic [31:0] host_rdata_q;
  logic        host_rvalid_q;

`ifdef DMEM_ARB_FAIR_EN
  localparam logic [7:0] WAIT_MAX = 8'(HOST_WAIT_MAX);

  logic [7:0] wait_cnt;

  // Host also wins once it has lost WAIT_MAX consecutive cycles to the core.
  assign host_win = bus.host_req & (~bus.core_req | (wait_cnt == WAIT_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_HOST || host_win || !bus.host_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign host_win = bus.host_req & ~bus.core_req;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_CORE;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      host_rvalid_q <= 1'b0;
      case (state)
        S_CORE: if (host_win) state <= S_HOST;
        S_HOST: begin
          // Exactly one host beat per grant; the read result is captured here.
          state <= S_CORE;
          if (!bus.host_we) begin
            host_rdata_q  <= bus.mem_rdata;
            host_rvalid_q <= 1'b1;
          end
        end
        default: state <= S_CORE;
      endcase
    end
  end

  logic in_host;
  assign in_host = (state == S_HOST);

  assign bus.mem_addr    = in_host ? bus.host_addr  : bus.core_addr;
  assign bus.mem_wdata   = in_host ? bus.host_wdata : bus.core_wdata;
  assign bus.mem_wsel    = in_host ? bus.host_wsel  : bus.core_wsel;
  assign bus.mem_rsel    = in_host ? bus.host_rsel  : bus.core_rsel;
  assign bus.mem_rw      = in_host ? bus.host_we    : (bus.core_req & bus.core_we);

  assign bus.host_gnt    = in_host;
  assign bus.core_stall  = in_host & bus.core_req;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a word-wide DMEM model behind the port,
// scoreboard queues for host read data and core load data.
module tb_dmem_arbiter;

  localparam int HOST_BOUND = 40;

  logic clk;
  logic reset;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.HOST_WAIT_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMEM model: combinational read, write on the rising edge.
  logic [31:0] dmem [0:255];
  assign bus.mem_rdata = dmem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_rw) dmem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] host_q [$];
  logic [31:0] core_q [$];

  // Issues one host access and waits for its grant; reports what followed.
  task automatic host_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output logic rv, output logic [31:0] rd,
                             output logic rv_after);
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wdata;
    bus.host_wsel  = 2'b11;
    bus.host_rsel  = 3'b010;
    bus.host_req   = 1'b1;
    lat = -1;
    for (int i = 1; i <= HOST_BOUND; i++) begin
      @(negedge clk); #1;
      if (bus.host_gnt) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
    bus.host_req = 1'b0;
    #1;
    rv = bus.host_rvalid;
    rd = bus.host_rdata;
    @(negedge clk); #1;
    rv_after = bus.host_rvalid;
  endtask

  task automatic core_idle();
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_addr  = 32'h0;
    bus.core_wdata = 32'h0;
    bus.core_wsel  = 2'b00;
    bus.core_rsel  = 3'b000;
  endtask

  task automatic test_reset_values();
    reset = 1'b1;
    core_idle();
    bus.host_req = 1'b0;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.host_wsel = '0; bus.host_rsel = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.host_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt: got %b want 0", bus.host_gnt); end
    n_cmp++; if (bus.host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", bus.host_rvalid); end
    n_cmp++; if (bus.host_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.host_rdata); end
    n_cmp++; if (bus.core_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", bus.core_stall); end
    n_cmp++; if (bus.mem_rw !== 1'b0) begin n_bad++; $display("FAIL rst_mem_rw_idle: got %b want 0", bus.mem_rw); end
    bus.core_req = 1'b1; bus.core_we = 1'b1;
    #1;
    n_cmp++; if (bus.mem_rw !== 1'b1) begin n_bad++; $display("FAIL rst_mem_rw_store: got %b want 1", bus.mem_rw); end
    core_idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_host_wr_rd();
    int lat; logic rv; logic rv2; logic [31:0] rd; logic [31:0] exp;
    host_access(1'b1, 32'h40, 32'hDEADBEEF, lat, rv, rd, rv2);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_latency: got %0d want 1", lat); end
    n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL wr_no_rvalid: got %b want 0", rv); end
    host_q.push_back(32'hDEADBEEF);
    host_access(1'b0, 32'h40, 32'h0, lat, rv, rd, rv2);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rd_latency: got %0d want 1", lat); end
    n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid: got %b want 1", rv); end
    exp = (host_q.size() > 0) ? host_q.pop_front() : 32'hx;
    n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL rd_data: got %h want %h", rd, exp); end
    n_cmp++; if (rv2 !== 1'b0) begin n_bad++; $display("FAIL rd_rvalid_pulse: got %b want 0", rv2); end
  endtask

  // Asynchronous reset in the middle of a host read slot with the core waiting.
  task automatic test_reset_mid_read();
    int rv_cnt;
    bus.host_we = 1'b0; bus.host_addr = 32'h40; bus.host_req = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.host_gnt !== 1'b1) begin n_bad++; $display("FAIL rm_gnt_before: got %b want 1", bus.host_gnt); end
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h80;
    #1;
    n_cmp++; if (bus.core_stall !== 1'b1) begin n_bad++; $display("FAIL rm_stall_before: got %b want 1", bus.core_stall); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.host_gnt !== 1'b0) begin n_bad++; $display("FAIL rm_gnt: got %b want 0", bus.host_gnt); end
    n_cmp++; if (bus.core_stall !== 1'b0) begin n_bad++; $display("FAIL rm_stall: got %b want 0", bus.core_stall); end
    n_cmp++; if (bus.host_rdata !== 32'h0) begin n_bad++; $display("FAIL rm_rdata: got %h want 0", bus.host_rdata); end
    n_cmp++; if (bus.mem_addr !== 32'h80) begin n_bad++; $display("FAIL rm_mem_addr: got %h want 80", bus.mem_addr); end
    rv_cnt = (bus.host_rvalid === 1'b1) ? 1 : 0;
    @(negedge clk);
    bus.host_req = 1'b0; core_idle(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; if (bus.host_rvalid !== 1'b0) rv_cnt++;
      @(negedge clk);
    end
    #1;
    n_cmp++; if (rv_cnt !== 0) begin n_bad++; $display("FAIL rm_no_rvalid: got %0d pulses want 0", rv_cnt); end
  endtask

  task automatic test_collision();
    int stall_cnt = 0; logic [31:0] exp;
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'h80;
    bus.core_wdata = 32'h12345678; bus.core_wsel = 2'b10; bus.core_rsel = 3'b101;
    #1;
    n_cmp++; if (bus.mem_rw !== 1'b1) begin n_bad++; $display("FAIL col_store_rw: got %b want 1", bus.mem_rw); end
    n_cmp++; if ({bus.mem_wsel, bus.mem_rsel} !== 5'b10_101) begin n_bad++; $display("FAIL col_core_sel: got %b want 10101", {bus.mem_wsel, bus.mem_rsel}); end
    if (bus.core_stall) stall_cnt++;
    @(negedge clk);
    core_idle();
    bus.host_we = 1'b0; bus.host_addr = 32'h40; bus.host_wsel = 2'b01; bus.host_rsel = 3'b100;
    bus.host_req = 1'b1;
    host_q.push_back(32'hDEADBEEF);
    #1;
    n_cmp++; if (bus.host_gnt !== 1'b0) begin n_bad++; $display("FAIL col_gnt_early: got %b want 0", bus.host_gnt); end
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h80;
    core_q.push_back(32'h12345678);
    #1;
    if (bus.core_stall) stall_cnt++;
    n_cmp++; if (bus.host_gnt !== 1'b1) begin n_bad++; $display("FAIL col_gnt: got %b want 1", bus.host_gnt); end
    n_cmp++; if (bus.mem_addr !== 32'h40) begin n_bad++; $display("FAIL col_host_addr: got %h want 40", bus.mem_addr); end
    n_cmp++; if ({bus.mem_wsel, bus.mem_rsel} !== 5'b01_100) begin n_bad++; $display("FAIL col_host_sel: got %b want 01100", {bus.mem_wsel, bus.mem_rsel}); end
    @(negedge clk);
    bus.host_req = 1'b0;
    #1;
    if (bus.core_stall) stall_cnt++;
    exp = (core_q.size() > 0) ? core_q.pop_front() : 32'hx;
    n_cmp++; if (bus.core_rdata !== exp) begin n_bad++; $display("FAIL col_load: got %h want %h", bus.core_rdata, exp); end
    exp = (host_q.size() > 0) ? host_q.pop_front() : 32'hx;
    n_cmp++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== exp) begin
      n_bad++; $display("FAIL col_host_rd: got v=%b %h want v=1 %h", bus.host_rvalid, bus.host_rdata, exp);
    end
    @(negedge clk);
    core_idle();
    #1;
    if (bus.core_stall) stall_cnt++;
    n_cmp++; if (stall_cnt !== 1) begin n_bad++; $display("FAIL col_stall_cycles: got %0d want 1", stall_cnt); end
  endtask

`ifndef DMEM_ARB_FAIR_EN
  task automatic test_strict_busy();
    int gnt_busy = 0; int gnt_after = 0; int first = -1; int lat; logic rv; logic rv2; logic [31:0] rd; logic [31:0] exp;
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h80;
    bus.host_we = 1'b1; bus.host_addr = 32'hC0; bus.host_wdata = 32'h5A5A1234; bus.host_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin @(negedge clk); #1; end else #1;
      if (bus.host_gnt) gnt_busy++;
    end
    n_cmp++; if (gnt_busy !== 0) begin n_bad++; $display("FAIL strict_busy_gnt: got %0d grants want 0", gnt_busy); end
    @(negedge clk);
    bus.core_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); if (first >= 0) bus.host_req = 1'b0; end
      #1;
      if (bus.host_gnt) begin gnt_after++; if (first < 0) first = i; end
    end
    n_cmp++; if (first !== 1) begin n_bad++; $display("FAIL strict_gnt_latency: got %0d want 1", first); end
    n_cmp++; if (gnt_after !== 1) begin n_bad++; $display("FAIL strict_gnt_once: got %0d want 1", gnt_after); end
    host_q.push_back(32'h5A5A1234);
    host_access(1'b0, 32'hC0, 32'h0, lat, rv, rd, rv2);
    exp = (host_q.size() > 0) ? host_q.pop_front() : 32'hx;
    n_cmp++; if (rv !== 1'b1 || rd !== exp) begin n_bad++; $display("FAIL strict_readback: got v=%b %h want v=1 %h", rv, rd, exp); end
  endtask
`else
  task automatic test_fair_busy();
    int first = -1; int stalls = 0; int cnt_bad = 0; logic drop = 1'b0; logic [31:0] exp;
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h80;
    bus.host_we = 1'b0; bus.host_addr = 32'h40; bus.host_req = 1'b1;
    host_q.push_back(32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(negedge clk); if (drop) bus.host_req = 1'b0; end
      #1;
      if (bus.host_gnt) begin
        if (first < 0) first = i;
        drop = 1'b1;
      end
      if (first >= 0 && i <= first + 1 && dut.wait_cnt !== 8'd0) cnt_bad++;
      if (bus.core_stall) stalls++;
      if (bus.host_rvalid) begin
        exp = (host_q.size() > 0) ? host_q.pop_front() : 32'hx;
        n_cmp++; if (bus.host_rdata !== exp) begin n_bad++; $display("FAIL fair_rdata: got %h want %h", bus.host_rdata, exp); end
      end
    end
    n_cmp++; if (first !== 5) begin n_bad++; $display("FAIL fair_gnt_latency: got %0d want 5", first); end
    n_cmp++; if (stalls !== 1) begin n_bad++; $display("FAIL fair_stall_cycles: got %0d want 1", stalls); end
    n_cmp++; if (cnt_bad !== 0) begin n_bad++; $display("FAIL fair_wait_cnt_clear: got %0d nonzero samples want 0", cnt_bad); end
    n_cmp++; if (host_q.size() !== 0) begin n_bad++; $display("FAIL fair_rvalid_missing: got %0d pending want 0", host_q.size()); end
    core_idle();
    host_q.delete();
  endtask
`endif

  task automatic test_reset_in_host_write();
    int lat; logic rv; logic rv2; logic [31:0] rd; logic [31:0] exp; int rv_cnt = 0;
    core_idle();
    bus.core_addr = 32'h80;
    host_access(1'b1, 32'h100, 32'h0BADF00D, lat, rv, rd, rv2);
    bus.host_we = 1'b1; bus.host_addr = 32'h100; bus.host_wdata = 32'hCAFEF00D; bus.host_req = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.host_gnt !== 1'b1 || bus.mem_rw !== 1'b1) begin n_bad++; $display("FAIL rw_gnt_before: got gnt=%b rw=%b want 1 1", bus.host_gnt, bus.mem_rw); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.host_gnt !== 1'b0) begin n_bad++; $display("FAIL rw_gnt_drop: got %b want 0", bus.host_gnt); end
    n_cmp++; if (bus.mem_rw !== 1'b0) begin n_bad++; $display("FAIL rw_mem_rw_drop: got %b want 0", bus.mem_rw); end
    @(negedge clk);
    bus.host_req = 1'b0; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; if (bus.host_rvalid !== 1'b0) rv_cnt++;
      @(negedge clk);
    end
    #1;
    n_cmp++; if (rv_cnt !== 0) begin n_bad++; $display("FAIL rw_no_rvalid: got %0d pulses want 0", rv_cnt); end
    host_q.push_back(32'h0BADF00D);
    host_access(1'b0, 32'h100, 32'h0, lat, rv, rd, rv2);
    exp = (host_q.size() > 0) ? host_q.pop_front() : 32'hx;
    n_cmp++; if (rv !== 1'b1 || rd !== exp) begin n_bad++; $display("FAIL rw_dropped_write: got v=%b %h want v=1 %h", rv, rd, exp); end
    host_access(1'b1, 32'h100, 32'hCAFEF00D, lat, rv, rd, rv2);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rw_reissue_latency: got %0d want 1", lat); end
    host_q.push_back(32'hCAFEF00D);
    host_access(1'b0, 32'h100, 32'h0, lat, rv, rd, rv2);
    exp = (host_q.size() > 0) ? host_q.pop_front() : 32'hx;
    n_cmp++; if (rv !== 1'b1 || rd !== exp) begin n_bad++; $display("FAIL rw_reissue_data: got v=%b %h want v=1 %h", rv, rd, exp); end
  endtask

  // Back-to-back host requests with an idle core: grants never occupy two adjacent cycles.
  task automatic test_back_to_back();
    int gnts = 0; int adjacent = 0; logic prev = 1'b0;
    core_idle();
    bus.host_we = 1'b0; bus.host_addr = 32'h40; bus.host_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (bus.host_gnt) begin gnts++; if (prev) adjacent++; end
      prev = bus.host_gnt;
    end
    bus.host_req = 1'b0;
    n_cmp++; if (gnts !== 4) begin n_bad++; $display("FAIL b2b_grants: got %0d want 4", gnts); end
    n_cmp++; if (adjacent !== 0) begin n_bad++; $display("FAIL b2b_adjacent: got %0d want 0", adjacent); end
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    test_reset_values();
    test_host_wr_rd();
    test_reset_mid_read();
    test_collision();
`ifndef DMEM_ARB_FAIR_EN
    test_strict_busy();
`else
    test_fair_busy();
`endif
    test_reset_in_host_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
